// File: rtl/pong_renderer.sv
// Purpose : Pong game state (paddles, ball, scores, serve) plus per-pixel colour for a 1280x800 raster.
// Latency : RGB one cycle after the pixel inputs; game state advances on the cycle after frame_start.
// Backpressure: none; one pixel is accepted every cycle and game updates are never stalled.
// Ports   : clk/reset_n (sync, active-low); pixel_x/pixel_y/active from the timing generator;
//           frame_start once per frame; l_up/l_dn/r_up/r_dn paddle buttons;
//           o_red/o_green/o_blue pixel colour; score_l/score_r BCD scores; point one-cycle score pulse.
module pong_renderer #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 800,
    parameter int PADDLE_W     = 16,
    parameter int PADDLE_H     = 128,
    parameter int BALL         = 16,
    parameter int LEFT_X       = 32,
    parameter int RIGHT_X      = 1232,
    parameter int PADDLE_SPEED = 8,
    parameter int BALL_SPEED   = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        active,
    input  logic        frame_start,
    input  logic        l_up,
    input  logic        l_dn,
    input  logic        r_up,
    input  logic        r_dn,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        point
);

    // All geometry is compared in 12 bits so sums such as x + BALL never wrap.
    localparam logic [11:0] K_BS    = 12'(BALL_SPEED);
    localparam logic [11:0] K_BALL  = 12'(BALL);
    localparam logic [11:0] K_PW    = 12'(PADDLE_W);
    localparam logic [11:0] K_PH    = 12'(PADDLE_H);
    localparam logic [11:0] K_PS    = 12'(PADDLE_SPEED);
    localparam logic [11:0] K_LX    = 12'(LEFT_X);
    localparam logic [11:0] K_RX    = 12'(RIGHT_X);
    localparam logic [11:0] K_LCONT = 12'(LEFT_X + PADDLE_W);
    localparam logic [11:0] K_XMAX  = 12'(H_ACTIVE - BALL);
    localparam logic [11:0] K_YMAX  = 12'(V_ACTIVE - BALL);
    localparam logic [11:0] K_PYMAX = 12'(V_ACTIVE - PADDLE_H);
    localparam logic [11:0] K_NET0  = 12'(H_ACTIVE / 2 - 2);
    localparam logic [11:0] K_NET1  = 12'(H_ACTIVE / 2 + 1);
    localparam logic [10:0] K_CX    = 11'((H_ACTIVE - BALL) / 2);
    localparam logic [9:0]  K_CY    = 10'((V_ACTIVE - BALL) / 2);
    localparam logic [9:0]  K_PY0   = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [5:0]  K_SLAST = 6'(SERVE_FRAMES - 1);

    typedef enum logic {ST_SERVE, ST_PLAY} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [10:0] r_bx, w_bx_nxt;
    logic [9:0]  r_by, w_by_nxt;
    logic        r_dx, w_dx_nxt;        // 1 = moving right
    logic        r_dy, w_dy_nxt;        // 1 = moving down
    logic [9:0]  r_lp, r_rp, w_lp_nxt, w_rp_nxt;
    logic [3:0]  r_score_l, r_score_r, w_sl_nxt, w_sr_nxt;
    logic        r_point, w_point_nxt;
    logic [3:0]  r_red, r_green, r_blue, w_lvl;

    logic [11:0] w_bx, w_by, w_lp, w_rp, w_px, w_py;
    logic        w_miss_l, w_miss_r, w_hit_l, w_hit_r;
    logic        w_in_ball, w_in_pad, w_in_net;

    assign w_bx = {1'b0, r_bx};
    assign w_by = {2'b00, r_by};
    assign w_lp = {2'b00, r_lp};
    assign w_rp = {2'b00, r_rp};
    assign w_px = {1'b0, pixel_x};
    assign w_py = {2'b00, pixel_y};

    function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
        logic [11:0] y12;
        logic [9:0]  res;
        y12 = {2'b00, y};
        res = y;
        if (up && !dn)
            res = (y12 < K_PS) ? 10'd0 : 10'(y12 - K_PS);
        else if (dn && !up)
            res = (y12 + K_PS > K_PYMAX) ? 10'(K_PYMAX) : 10'(y12 + K_PS);
        return res;
    endfunction

    assign w_lp_nxt = paddle_next(r_lp, l_up, l_dn);
    assign w_rp_nxt = paddle_next(r_rp, r_up, r_dn);

    // w_miss_l: ball left the left edge, right player scores (and vice versa).
    assign w_miss_l = !r_dx && (w_bx < K_BS);
    assign w_miss_r =  r_dx && (w_bx + K_BS > K_XMAX);
    // Hit when this frame's step would reach or cross the paddle face.
    assign w_hit_l  = !r_dx && (w_bx >= K_LCONT) && (w_bx <= K_LCONT + K_BS)
                      && (w_by + K_BALL > w_lp) && (w_by < w_lp + K_PH);
    assign w_hit_r  =  r_dx && (w_bx + K_BALL <= K_RX) && (w_bx + K_BALL + K_BS >= K_RX)
                      && (w_by + K_BALL > w_rp) && (w_by < w_rp + K_PH);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bx_nxt    = r_bx;
        w_by_nxt    = r_by;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_sl_nxt    = r_score_l;
        w_sr_nxt    = r_score_r;
        w_point_nxt = 1'b0;
        case (r_state)
            ST_SERVE: begin
                if (r_cnt == K_SLAST) begin
                    w_cnt_nxt   = 6'd0;
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            ST_PLAY: begin
                if (!r_dy && w_by < K_BS) begin
                    w_by_nxt = 10'd0;
                    w_dy_nxt = 1'b1;
                end else if (r_dy && w_by + K_BS > K_YMAX) begin
                    w_by_nxt = 10'(K_YMAX);
                    w_dy_nxt = 1'b0;
                end else begin
                    w_by_nxt = r_dy ? 10'(w_by + K_BS) : 10'(w_by - K_BS);
                end

                if (w_miss_l || w_miss_r) begin
                    if (w_miss_l)
                        w_sr_nxt = (r_score_r == 4'd9) ? 4'd0 : r_score_r + 4'd1;
                    else
                        w_sl_nxt = (r_score_l == 4'd9) ? 4'd0 : r_score_l + 4'd1;
                    // Ball keeps heading toward the side that just conceded.
                    w_dx_nxt    = w_miss_r;
                    w_bx_nxt    = K_CX;
                    w_by_nxt    = K_CY;
                    w_state_nxt = ST_SERVE;
                    w_cnt_nxt   = 6'd0;
                    w_point_nxt = 1'b1;
                end else if (w_hit_l) begin
                    w_bx_nxt = 11'(K_LCONT);
                    w_dx_nxt = 1'b1;
                end else if (w_hit_r) begin
                    w_bx_nxt = 11'(K_RX - K_BALL);
                    w_dx_nxt = 1'b0;
                end else begin
                    w_bx_nxt = r_dx ? 11'(w_bx + K_BS) : 11'(w_bx - K_BS);
                end
            end
            default: ;
        endcase
    end

    assign w_in_ball = (w_px >= w_bx) && (w_px < w_bx + K_BALL)
                       && (w_py >= w_by) && (w_py < w_by + K_BALL);
    assign w_in_pad  = ((w_px >= K_LX) && (w_px < K_LX + K_PW) && (w_py >= w_lp) && (w_py < w_lp + K_PH))
                    || ((w_px >= K_RX) && (w_px < K_RX + K_PW) && (w_py >= w_rp) && (w_py < w_rp + K_PH));
    // Dashed net: 16-line segments, drawn where pixel_y[4] is low.
    assign w_in_net  = (w_px >= K_NET0) && (w_px <= K_NET1) && !pixel_y[4];

    always_comb begin
        w_lvl = 4'h0;
        if (active) begin
            if (w_in_ball || w_in_pad)
                w_lvl = 4'hF;
            else if (w_in_net)
                w_lvl = 4'h8;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_SERVE;
            r_cnt     <= 6'd0;
            r_bx      <= K_CX;
            r_by      <= K_CY;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_lp      <= K_PY0;
            r_rp      <= K_PY0;
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_point   <= 1'b0;
            r_red     <= 4'h0;
            r_green   <= 4'h0;
            r_blue    <= 4'h0;
        end else begin
            r_red   <= w_lvl;
            r_green <= w_lvl;
            r_blue  <= w_lvl;
            r_point <= frame_start & w_point_nxt;
            if (frame_start) begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_bx      <= w_bx_nxt;
                r_by      <= w_by_nxt;
                r_dx      <= w_dx_nxt;
                r_dy      <= w_dy_nxt;
                r_lp      <= w_lp_nxt;
                r_rp      <= w_rp_nxt;
                r_score_l <= w_sl_nxt;
                r_score_r <= w_sr_nxt;
            end
        end
    end

    assign o_red   = r_red;
    assign o_green = r_green;
    assign o_blue  = r_blue;
    assign score_l = r_score_l;
    assign score_r = r_score_r;
    assign point   = r_point;

endmodule
